// File: rtl/ms_sample_feeder_pkg.sv
// Shared types for the master/slave sample pair: section encoding and 32-bit signed rails.
package ms_feeder_types;

    typedef enum logic {
        section_idle = 1'b0,
        section_gap  = 1'b1
    } sections_e;

    localparam logic signed [31:0] INT32_MAX = 32'sh7fff_ffff;
    localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;

endpackage

// File: rtl/ms_sample_feeder_if.sv
// Feeder bus: blocking-source input side (sig/sync/notify) plus the published-sum output side.
interface ms_sample_feeder_if;

    logic signed [31:0] b_in_sig;
    logic               b_in_sync;
    logic               b_in_notify;
    logic signed [31:0] s_out;
    logic               s_out_sync;
    logic               s_out_frame;

    modport master (
        input  b_in_sig,
        input  b_in_sync,
        output b_in_notify,
        output s_out,
        output s_out_sync,
        output s_out_frame
    );

    modport slave (
        output b_in_sig,
        output b_in_sync,
        input  b_in_notify,
        input  s_out,
        input  s_out_sync,
        input  s_out_frame
    );

endinterface

// File: rtl/ms_sample_feeder_sat_add32.sv
// Combinational signed 32+32 adder clamped to the int32 rails; zero latency, no flow control.
module sat_add32
    import ms_feeder_types::*;
(
    input  logic signed [31:0] a,
    input  logic signed [31:0] b,
    output logic signed [31:0] y
);

    logic signed [32:0] wide;

    always_comb begin
        wide = {a[31], a} + {b[31], b};
        if (wide[32] != wide[31]) begin
            y = wide[32] ? INT32_MIN : INT32_MAX;
        end else begin
            y = wide[31:0];
        end
    end

endmodule

// File: rtl/ms_sample_feeder.sv
// Saturating running-sum feeder: one publish per accepted source value, latency 1 cycle;
// notify drops for MIN_GAP cycles after each transfer so the consumer sees every update.
module ms_sample_feeder
    import ms_feeder_types::*;
#(
    parameter int MIN_GAP   = 2,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    ms_sample_feeder_if.master   bus
);

    localparam bit              GAP_EN     = (MIN_GAP > 0);
    localparam bit              FRAME_EN   = (FRAME_LEN > 0);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_EN ? MIN_GAP - 1 : 0);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_EN ? FRAME_LEN - 1 : 0);

    sections_e          section, section_nxt;
    logic [CNT_W-1:0]   gap_cnt, gap_cnt_nxt;
    logic [CNT_W-1:0]   sample_cnt, sample_cnt_nxt;
    logic signed [31:0] acc, acc_nxt;
    logic signed [31:0] sum;
    logic signed [31:0] s_out_q, s_out_nxt;
    logic               sync_q, sync_nxt;
    logic               frame_q, frame_nxt;
    logic               notify_q, notify_nxt;
    logic               xfer;

    sat_add32 u_sat_add (
        .a (acc),
        .b (bus.b_in_sig),
        .y (sum)
    );

    assign xfer = bus.b_in_sync && notify_q;

    always_comb begin
        section_nxt    = section;
        gap_cnt_nxt    = gap_cnt;
        sample_cnt_nxt = sample_cnt;
        acc_nxt        = acc;
        s_out_nxt      = s_out_q;
        sync_nxt       = 1'b0;
        frame_nxt      = 1'b0;
        notify_nxt     = notify_q;

        case (section)
            section_idle: begin
                notify_nxt = 1'b1;
                if (xfer) begin
                    s_out_nxt = sum;
                    sync_nxt  = 1'b1;
                    // The last sample of a frame is published but not carried forward.
                    if (FRAME_EN && (sample_cnt == FRAME_LAST)) begin
                        frame_nxt      = 1'b1;
                        acc_nxt        = '0;
                        sample_cnt_nxt = '0;
                    end else begin
                        acc_nxt        = sum;
                        sample_cnt_nxt = sample_cnt + CNT_W'(1);
                    end
                    if (GAP_EN) begin
                        notify_nxt  = 1'b0;
                        gap_cnt_nxt = GAP_LOAD;
                        section_nxt = section_gap;
                    end
                end
            end
            section_gap: begin
                notify_nxt = 1'b0;
                if (gap_cnt == '0) begin
                    section_nxt = section_idle;
                    notify_nxt  = 1'b1;
                end else begin
                    gap_cnt_nxt = gap_cnt - CNT_W'(1);
                end
            end
            default: begin
                section_nxt = section_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            section    <= section_idle;
            gap_cnt    <= '0;
            sample_cnt <= '0;
            acc        <= '0;
            s_out_q    <= '0;
            sync_q     <= 1'b0;
            frame_q    <= 1'b0;
            notify_q   <= 1'b0;
        end else begin
            section    <= section_nxt;
            gap_cnt    <= gap_cnt_nxt;
            sample_cnt <= sample_cnt_nxt;
            acc        <= acc_nxt;
            s_out_q    <= s_out_nxt;
            sync_q     <= sync_nxt;
            frame_q    <= frame_nxt;
            notify_q   <= notify_nxt;
        end
    end

    assign bus.s_out       = s_out_q;
    assign bus.s_out_sync  = sync_q;
    assign bus.s_out_frame = frame_q;
    assign bus.b_in_notify = notify_q;

endmodule

// File: tb/tb_ms_sample_feeder.sv
// Directed bench: default feeder (MIN_GAP=2, FRAME_LEN=4) and a back-to-back feeder (MIN_GAP=0, FRAME_LEN=0).
module tb_ms_sample_feeder;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ms_sample_feeder_if bus_a ();
    ms_sample_feeder_if bus_b ();

    ms_sample_feeder #(.MIN_GAP(2), .FRAME_LEN(4), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.master)
    );

    ms_sample_feeder #(.MIN_GAP(0), .FRAME_LEN(0), .CNT_W(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [31:0] din;
        logic signed [31:0] dout;
        logic               frame;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Offer one value to dut_a, wait for notify, then check the publish and the pulse clearing.
    task automatic send(input int idx, input logic signed [31:0] v,
                        input logic signed [31:0] exp, input logic exp_f);
        int n;
        n = 0;
        @(negedge clk);
        bus_a.b_in_sig  = v;
        bus_a.b_in_sync = 1'b1;
        while (!bus_a.b_in_notify && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL vec%0d_notify_timeout: got notify=0, expected notify=1 within 20 cycles", idx);
            bus_a.b_in_sync = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus_a.b_in_sync = 1'b0;
            chk($sformatf("vec%0d_s_out", idx), bus_a.s_out, exp);
            chk($sformatf("vec%0d_sync", idx), 32'(bus_a.s_out_sync), 32'd1);
            chk($sformatf("vec%0d_frame", idx), 32'(bus_a.s_out_frame), 32'(exp_f));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_sync_clear", idx), 32'(bus_a.s_out_sync), 32'd0);
            chk($sformatf("vec%0d_s_out_hold", idx), bus_a.s_out, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000 time units");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_sync;
        logic [3:0] exp_notify;
        int         exp_sout [4];

        checks = 0;
        errors = 0;

        vecs[0]  = '{32'sd5, 32'sd5, 1'b0};
        vecs[1]  = '{32'sd7, 32'sd12, 1'b0};
        vecs[2]  = '{32'sd1, 32'sd13, 1'b0};
        vecs[3]  = '{32'sd4, 32'sd17, 1'b1};
        vecs[4]  = '{32'sd1, 32'sd1, 1'b0};
        vecs[5]  = '{32'sd2, 32'sd3, 1'b0};
        vecs[6]  = '{32'sd3, 32'sd6, 1'b0};
        vecs[7]  = '{32'sd4, 32'sd10, 1'b1};
        vecs[8]  = '{32'sd10, 32'sd10, 1'b0};
        vecs[9]  = '{32'sd2147483630, 32'sd2147483640, 1'b0};
        vecs[10] = '{32'sd100, 32'sd2147483647, 1'b0};
        vecs[11] = '{-32'sd7, 32'sd2147483640, 1'b1};
        vecs[12] = '{32'sh8000_0000, 32'sh8000_0000, 1'b0};
        vecs[13] = '{-32'sd1, 32'sh8000_0000, 1'b0};
        vecs[14] = '{32'sd5, -32'sd2147483643, 1'b0};
        vecs[15] = '{32'sd0, -32'sd2147483643, 1'b1};

        rst = 1'b0;
        bus_a.b_in_sig = '0; bus_a.b_in_sync = 1'b0;
        bus_b.b_in_sig = '0; bus_b.b_in_sync = 1'b0;
        #1;
        chk("rst_s_out", bus_a.s_out, 32'sd0);
        chk("rst_notify", 32'(bus_a.b_in_notify), 32'd0);
        chk("rst_sync", 32'(bus_a.s_out_sync), 32'd0);
        chk("rst_frame", 32'(bus_a.s_out_frame), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_notify", 32'(bus_a.b_in_notify), 32'd0);

        // Release: notify rises on the first edge, nothing is published without a source.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("release_notify_pre", 32'(bus_a.b_in_notify), 32'd0);
        @(posedge clk);
        #1;
        chk("release_notify_post", 32'(bus_a.b_in_notify), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("idle_s_out_%0d", i), bus_a.s_out, 32'sd0);
            chk($sformatf("idle_sync_%0d", i), 32'(bus_a.s_out_sync), 32'd0);
            chk($sformatf("idle_notify_%0d", i), 32'(bus_a.b_in_notify), 32'd1);
        end

        // Source offers continuously: 5 then 7; the gap holds notify low for two cycles.
        exp_sync   = 4'b1001;
        exp_notify = 4'b0100;
        exp_sout   = '{5, 5, 5, 12};
        @(negedge clk);
        bus_a.b_in_sig  = 32'sd5;
        bus_a.b_in_sync = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) bus_a.b_in_sig = 32'sd7;
            chk($sformatf("cont_sync_%0d", i), 32'(bus_a.s_out_sync), 32'(exp_sync[i]));
            chk($sformatf("cont_notify_%0d", i), 32'(bus_a.b_in_notify), 32'(exp_notify[i]));
            chk($sformatf("cont_s_out_%0d", i), bus_a.s_out, exp_sout[i]);
        end
        bus_a.b_in_sync = 1'b0;

        // Reset while in the gap: everything clears asynchronously.
        rst = 1'b0;
        #1;
        chk("gaprst_s_out", bus_a.s_out, 32'sd0);
        chk("gaprst_sync", 32'(bus_a.s_out_sync), 32'd0);
        chk("gaprst_notify", 32'(bus_a.b_in_notify), 32'd0);
        chk("gaprst_frame", 32'(bus_a.s_out_frame), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Table starts from acc=0, which also confirms the reset discarded the old sum.
        for (int i = 0; i < 16; i++) begin
            send(i, vecs[i].din, vecs[i].dout, vecs[i].frame);
        end

        // Back-to-back feeder: sync held three cycles gives three consecutive publishes.
        @(negedge clk);
        chk("b_notify_idle", 32'(bus_b.b_in_notify), 32'd1);
        bus_b.b_in_sig  = 32'sd1;
        bus_b.b_in_sync = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) bus_b.b_in_sync = 1'b0;
            chk($sformatf("b_sync_%0d", i), 32'(bus_b.s_out_sync), 32'd1);
            chk($sformatf("b_s_out_%0d", i), bus_b.s_out, 32'(i + 1));
            chk($sformatf("b_notify_%0d", i), 32'(bus_b.b_in_notify), 32'd1);
            chk($sformatf("b_frame_%0d", i), 32'(bus_b.s_out_frame), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("b_sync_clear", 32'(bus_b.s_out_sync), 32'd0);
        chk("b_s_out_hold", bus_b.s_out, 32'sd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
